// File: rtl/snn_mac_pkg.sv
// Shared types and helpers for the spike-gated MAC: FSM state encoding,
// a constant-foldable ceil(log2) and a width-parametrised saturating add.
package snn_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  // Wide enough for any practical accumulator plus the widest partial sum.
  localparam int SAT_CALC_W = 64;

  // ceil(log2(value)); returns 0 for value <= 1 so a single lane needs no tree levels.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Adds two sign-extended operands and clamps the result to the signed
  // range of 'width' bits. Operands are carried at SAT_CALC_W bits so the
  // raw sum never wraps before it is compared against the limits.
  function automatic logic signed [SAT_CALC_W-1:0] sat_add(
    input logic signed [SAT_CALC_W-1:0] a,
    input logic signed [SAT_CALC_W-1:0] b,
    input int                           width
  );
    logic signed [SAT_CALC_W-1:0] total;
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    total = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (total > max_v) begin
      return max_v;
    end else if (total < min_v) begin
      return min_v;
    end
    return total;
  endfunction

endpackage

// File: rtl/spike_lane_sum.sv
// Combinational gated adder tree: each lane contributes its sign-extended
// weight when its spike bit is set, and the lanes are summed pairwise in a
// balanced binary tree padded up to the next power of two.
module spike_lane_sum
  import snn_mac_pkg::*;
#(
  parameter int LANES   = 5,
  parameter int W_WIDTH = 8,
  parameter int PART_W  = W_WIDTH + clog2(LANES) + 1
) (
  input  logic [LANES-1:0]          spikes,
  input  logic [LANES*W_WIDTH-1:0]  weights,
  output logic signed [PART_W-1:0]  partial
);

  localparam int LEVELS = clog2(LANES);
  localparam int LEAVES = 1 << LEVELS;

  // Heap-ordered tree: node 0 is the root, leaves start at LEAVES-1.
  logic signed [PART_W-1:0] node [2*LEAVES-1];

  for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
    if (gi < LANES) begin : g_live
      assign node[LEAVES-1+gi] = spikes[gi]
                               ? PART_W'($signed(weights[gi*W_WIDTH +: W_WIDTH]))
                               : '0;
    end else begin : g_pad
      assign node[LEAVES-1+gi] = '0;
    end
  end

  for (genvar gi = 0; gi < LEAVES - 1; gi++) begin : g_node
    assign node[gi] = node[2*gi+1] + node[2*gi+2];
  end

  assign partial = node[0];

endmodule

// File: rtl/spike_mac_seq.sv
// Sequential spike-gated multiply-accumulate. A spike/weight vector is
// captured on accept, then summed LANES inputs per cycle through one shared
// lane adder tree, with the running total saturated after every chunk.
// The result is presented over a valid/ready handshake.
module spike_mac_seq
  import snn_mac_pkg::*;
#(
  parameter int N_IN      = 25,
  parameter int LANES     = 5,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           spikes,
  input  logic [N_IN*W_WIDTH-1:0]   weights,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      sum_out,
  output logic                      sat_flag
);

  localparam int CHUNKS = (N_IN + LANES - 1) / LANES;
  localparam int PAD_N  = CHUNKS * LANES;
  localparam int IDX_W  = (CHUNKS > 1) ? clog2(CHUNKS) : 1;
  localparam int PART_W = W_WIDTH + clog2(LANES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  mac_state_t state;
  mac_state_t next_state;

  logic [N_IN-1:0]          spikes_q;
  logic [N_IN*W_WIDTH-1:0]  weights_q;
  logic [IDX_W-1:0]         idx;
  logic [ACC_WIDTH-1:0]     acc;

  logic [PAD_N-1:0]         spikes_pad;
  logic [PAD_N*W_WIDTH-1:0] weights_pad;
  logic [LANES-1:0]         lane_spikes;
  logic [LANES*W_WIDTH-1:0] lane_weights;
  logic signed [PART_W-1:0] partial;

  logic signed [SAT_CALC_W-1:0] acc_ext;
  logic signed [SAT_CALC_W-1:0] part_ext;
  logic signed [SAT_CALC_W-1:0] raw_sum;
  logic signed [SAT_CALC_W-1:0] sat_sum;
  logic [ACC_WIDTH-1:0]         acc_next;
  logic                         clamped;
  logic                         accept;
  logic                         last_chunk;

  // Zero-pad the captured vector to a whole number of chunks so the final
  // chunk's missing lanes read as silent inputs.
  always_comb begin
    spikes_pad                        = '0;
    weights_pad                       = '0;
    spikes_pad[N_IN-1:0]              = spikes_q;
    weights_pad[N_IN*W_WIDTH-1:0]     = weights_q;
  end

  assign lane_spikes  = spikes_pad[int'(idx)*LANES +: LANES];
  assign lane_weights = weights_pad[int'(idx)*LANES*W_WIDTH +: LANES*W_WIDTH];

  spike_lane_sum #(
    .LANES   (LANES),
    .W_WIDTH (W_WIDTH),
    .PART_W  (PART_W)
  ) u_lane_sum (
    .spikes  (lane_spikes),
    .weights (lane_weights),
    .partial (partial)
  );

  // Saturating accumulate of the current chunk; a clamp is detected as the
  // saturated sum differing from the unbounded one.
  always_comb begin
    acc_ext  = {{(SAT_CALC_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    part_ext = {{(SAT_CALC_W-PART_W){partial[PART_W-1]}}, partial};
    raw_sum  = acc_ext + part_ext;
    sat_sum  = sat_add(acc_ext, part_ext, ACC_WIDTH);
    clamped  = (sat_sum != raw_sum);
    acc_next = sat_sum[ACC_WIDTH-1:0];
  end

  assign accept     = in_valid && (state == IDLE);
  assign last_chunk = (idx == LAST_IDX);

  // State register; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ACCUM;
      end
      ACCUM: begin
        if (last_chunk) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on accept, accumulate one chunk per ACCUM cycle, and
  // publish the final total as the chunk counter finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spikes_q  <= '0;
      weights_q <= '0;
      idx       <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sat_flag  <= 1'b0;
    end else if (accept) begin
      spikes_q  <= spikes;
      weights_q <= weights;
      idx       <= '0;
      acc       <= '0;
      sat_flag  <= 1'b0;
    end else if (state == ACCUM) begin
      acc <= acc_next;
      if (clamped) sat_flag <= 1'b1;
      if (last_chunk) begin
        idx     <= '0;
        sum_out <= acc_next;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
